// File: rtl/limb_pkg.sv
// rtl/limb_pkg.sv - shared constants and state type for the load/store unit
package limb_pkg;

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;
  localparam logic [1:0] PROT_DATA  = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RRESP = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-side memory bus between the load/store unit and memory
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] rdata;
  logic              abort;
  logic              write;
  logic              size;
  logic [1:0]        prot;
  logic [1:0]        trans;

  modport master (
    output addr, wdata, write, size, prot, trans,
    input  rdata, abort
  );

  modport slave (
    input  addr, wdata, write, size, prot, trans,
    output rdata, abort
  );
endinterface

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - load lane extract/rotate and store byte-lane merge
module byte_lane_unit #(
  parameter int W = 32
) (
  input  logic [1:0]   lane,
  input  logic         is_byte,
  input  logic [W-1:0] rdata,
  input  logic [7:0]   sbyte,
  output logic [W-1:0] load_data,
  output logic [W-1:0] merged
);

  logic [W-1:0] rot;

  // Rotating right by the lane puts the addressed byte in bits 7:0 for both LDR and LDRB.
  always_comb begin
    rot = rdata;
    case (lane)
      2'd1:    rot = {rdata[7:0],  rdata[W-1:8]};
      2'd2:    rot = {rdata[15:0], rdata[W-1:16]};
      2'd3:    rot = {rdata[23:0], rdata[W-1:24]};
      default: rot = rdata;
    endcase
  end

  assign load_data = is_byte ? {{(W-8){1'b0}}, rot[7:0]} : rot;

  always_comb begin
    merged = rdata;
    merged[{lane, 3'b000} +: 8] = sbyte;
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single LDR/STR/LDRB/STRB transfer engine with base writeback
module load_store_unit
  import limb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_byte,
  input  logic              req_pre,
  input  logic              req_up,
  input  logic              req_wback,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [ADDR_W-1:0] req_sdata,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rn,
  load_store_unit_if.master mem,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [ADDR_W-1:0] wb_data,
  output logic              wb_base_valid,
  output logic [3:0]        wb_rn,
  output logic [ADDR_W-1:0] wb_base,
  output logic              xfer_abort
);

  lsu_state_t state, state_nx;

  logic              load_q, byte_q, pre_q, wback_q, abort_q;
  logic [3:0]        rd_q, rn_q;
  logic [ADDR_W-1:0] sdata_q, eff_q, off_q, rdata_q;
  logic [ADDR_W-1:0] off_addr, eff_addr;
  logic [ADDR_W-1:0] load_data, merged;
  logic              accept;

  assign accept   = (state == IDLE) && req_valid;
  assign off_addr = req_up ? req_base + req_offset : req_base - req_offset;
  assign eff_addr = req_pre ? off_addr : req_base;

  byte_lane_unit #(.W(ADDR_W)) u_lane (
    .lane      (eff_q[1:0]),
    .is_byte   (byte_q),
    .rdata     (rdata_q),
    .sbyte     (sdata_q[7:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (req_load || req_byte) ? RADDR : WADDR;
      RADDR:   state_nx = RRESP;
      RRESP:   state_nx = (mem.abort || load_q) ? DONE : WADDR;
      WADDR:   state_nx = WRESP;
      WRESP:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      pre_q   <= 1'b0;
      wback_q <= 1'b0;
      abort_q <= 1'b0;
      rd_q    <= '0;
      rn_q    <= '0;
      sdata_q <= '0;
      eff_q   <= RESET_PC;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        load_q  <= req_load;
        byte_q  <= req_byte;
        pre_q   <= req_pre;
        wback_q <= req_wback;
        abort_q <= 1'b0;
        rd_q    <= req_rd;
        rn_q    <= req_rn;
        sdata_q <= req_sdata;
        eff_q   <= eff_addr;
        off_q   <= off_addr;
      end
      if (state == RRESP) begin
        if (mem.abort) abort_q <= 1'b1;
        else           rdata_q <= mem.rdata;
      end
      if (state == WRESP && mem.abort) abort_q <= 1'b1;
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    mem.addr      = {2'b00, eff_q[ADDR_W-1:2]};
    mem.size      = 1'b1;
    mem.prot      = PROT_DATA;
    mem.trans     = (state == RADDR || state == WADDR) ? TRANS_NSEQ : TRANS_IDLE;
    mem.write     = (state == WADDR);
    mem.wdata     = '0;
    if (state == WADDR) mem.wdata = byte_q ? merged : sdata_q;
    wb_valid      = (state == DONE) && load_q && !abort_q;
    // A load into its own base register keeps the loaded value, not the updated base.
    wb_base_valid = (state == DONE) && !abort_q && (!pre_q || wback_q)
                    && !(load_q && (rd_q == rn_q));
    xfer_abort    = (state == DONE) && abort_q;
    wb_rd         = rd_q;
    wb_rn         = rn_q;
    wb_data       = wb_valid ? load_data : '0;
    wb_base       = wb_base_valid ? off_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid, req_ready, req_load, req_byte, req_pre, req_up, req_wback;
  logic [31:0] req_base, req_offset, req_sdata;
  logic [3:0]  req_rd, req_rn;
  logic        wb_valid, wb_base_valid, xfer_abort;
  logic [3:0]  wb_rd, wb_rn;
  logic [31:0] wb_data, wb_base;
  logic        abort_drv;
  logic [31:0] rdata_r = 32'h0;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  int          wbv_at, wbb_at, abort_at, ready_at;
  logic [31:0] wbv_data, wbb_data, rd_addr_seen, wr_addr_seen, wr_data_seen;
  logic [3:0]  wbv_rd, wbb_rn;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) mem_bus ();
  assign mem_bus.rdata = rdata_r;
  assign mem_bus.abort = abort_drv;

  load_store_unit dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_load      (req_load),
    .req_byte      (req_byte),
    .req_pre       (req_pre),
    .req_up        (req_up),
    .req_wback     (req_wback),
    .req_base      (req_base),
    .req_offset    (req_offset),
    .req_sdata     (req_sdata),
    .req_rd        (req_rd),
    .req_rn        (req_rn),
    .mem           (mem_bus),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_base_valid (wb_base_valid),
    .wb_rn         (wb_rn),
    .wb_base       (wb_base),
    .xfer_abort    (xfer_abort)
  );

  // Word-addressed memory: write in the address phase, read data valid the following cycle.
  always @(posedge clk) begin
    if (mem_bus.trans == 2'b10) begin
      if (mem_bus.write) mem[mem_bus.addr[7:0]] <= mem_bus.wdata;
      else               rdata_r <= mem[mem_bus.addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic byt, input logic pre, input logic up,
                       input logic wb, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sd, input logic [3:0] rd, input logic [3:0] rn);
    @(negedge clk);
    req_load = ld; req_byte = byt; req_pre = pre; req_up = up; req_wback = wb;
    req_base = base; req_offset = off; req_sdata = sd; req_rd = rd; req_rn = rn;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_base = 32'h0; req_offset = 32'h0; req_sdata = 32'h0;
    wbv_at = 99; wbb_at = 99; abort_at = 99; ready_at = 99;
    wbv_data = NONE; wbb_data = NONE; wbv_rd = 4'hF; wbb_rn = 4'hF;
    rd_addr_seen = NONE; wr_addr_seen = NONE; wr_data_seen = NONE;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (mem_bus.trans == 2'b10 && !mem_bus.write && rd_addr_seen == NONE)
        rd_addr_seen = mem_bus.addr;
      if (mem_bus.trans == 2'b10 && mem_bus.write) begin
        wr_addr_seen = mem_bus.addr;
        wr_data_seen = mem_bus.wdata;
      end
      if (wb_valid)      begin wbv_at = n; wbv_data = wb_data; wbv_rd = wb_rd; end
      if (wb_base_valid) begin wbb_at = n; wbb_data = wb_base; wbb_rn = wb_rn; end
      if (xfer_abort)    abort_at = n;
      if (req_ready) begin
        ready_at = n;
        break;
      end
    end
  endtask

  initial begin
    n_reset = 1'b0; req_valid = 1'b0; abort_drv = 1'b0;
    req_load = 1'b0; req_byte = 1'b0; req_pre = 1'b0; req_up = 1'b0; req_wback = 1'b0;
    req_base = 32'h0; req_offset = 32'h0; req_sdata = 32'h0; req_rd = 4'h0; req_rn = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h41] = 32'hDEAD_BEEF;
    mem[8'h80] = 32'h1122_3344;
    mem[8'h04] = 32'hCAFE_F00D;
    mem[8'h09] = 32'h0102_0304;
    mem[8'h30] = 32'hA1B2_C3D4;
    mem[8'h01] = 32'h0000_0077;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_size",  {31'h0, mem_bus.size}, 32'h1);
    chk("rst_prot",  {30'h0, mem_bus.prot}, 32'h1);
    chk("rst_trans", {30'h0, mem_bus.trans}, 32'h0);
    chk("rst_write", {31'h0, mem_bus.write}, 32'h0);
    chk("rst_addr",  mem_bus.addr, 32'h0);
    chk("rst_pulses", {29'h0, wb_valid, wb_base_valid, xfer_abort}, 32'h0);
    n_reset = 1'b1;

    // LDR pre-indexed, no writeback
    issue(1, 0, 1, 1, 0, 32'h100, 32'h4, 32'h0, 4'd1, 4'd2);
    chk("ldr_addr",   rd_addr_seen, 32'h41);
    chk("ldr_wb_at",  wbv_at, 2);
    chk("ldr_data",   wbv_data, 32'hDEAD_BEEF);
    chk("ldr_rd",     {28'h0, wbv_rd}, 32'h1);
    chk("ldr_nobase", wbb_at, 99);
    chk("ldr_ready",  ready_at, 3);

    // STRB read-modify-write into lane 2
    issue(0, 1, 1, 1, 0, 32'h202, 32'h0, 32'hAB, 4'd4, 4'd5);
    chk("strb_raddr", rd_addr_seen, 32'h80);
    chk("strb_waddr", wr_addr_seen, 32'h80);
    chk("strb_wdata", wr_data_seen, 32'h11AB_3344);
    chk("strb_ready", ready_at, 5);
    chk("strb_mem",   mem[8'h80], 32'h11AB_3344);

    // LDR post-indexed, down
    issue(1, 0, 0, 0, 0, 32'h10, 32'h8, 32'h0, 4'd5, 4'd6);
    chk("post_addr",  rd_addr_seen, 32'h4);
    chk("post_data",  wbv_data, 32'hCAFE_F00D);
    chk("post_wb_at", wbv_at, 2);
    chk("post_bs_at", wbb_at, 2);
    chk("post_base",  wbb_data, 32'h8);
    chk("post_rn",    {28'h0, wbb_rn}, 32'h6);

    // LDR with rd == rn and writeback: load wins
    issue(1, 0, 1, 1, 1, 32'h20, 32'h4, 32'h0, 4'd3, 4'd3);
    chk("rdrn_data", wbv_data, 32'h0102_0304);
    chk("rdrn_nobs", wbb_at, 99);

    // STR aborted in WRESP
    abort_drv = 1'b1;
    issue(0, 0, 1, 1, 1, 32'h40, 32'h0, 32'h55, 4'd7, 4'd8);
    abort_drv = 1'b0;
    chk("abt_at",    abort_at, 2);
    chk("abt_nowb",  wbv_at, 99);
    chk("abt_nobs",  wbb_at, 99);
    chk("abt_ready", ready_at, 3);

    // LDRB lane 1 zero-extended, LDR lane 3 rotated
    issue(1, 1, 1, 1, 0, 32'hC1, 32'h0, 32'h0, 4'd2, 4'd9);
    chk("ldrb_data", wbv_data, 32'h0000_00C3);
    issue(1, 0, 1, 1, 0, 32'hC3, 32'h0, 32'h0, 4'd2, 4'd9);
    chk("ror_data",  wbv_data, 32'hB2C3_D4A1);

    // Address wrap past 2^32
    issue(1, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h8, 32'h0, 4'd1, 4'd2);
    chk("wrap_addr", rd_addr_seen, 32'h1);
    chk("wrap_data", wbv_data, 32'h77);
    chk("wrap_base", wbb_data, 32'h4);

    // Reset during RRESP of a post-indexed LDRB
    @(negedge clk);
    req_load = 1'b1; req_byte = 1'b1; req_pre = 1'b0; req_up = 1'b1; req_wback = 1'b0;
    req_base = 32'h104; req_offset = 32'h4; req_rd = 4'd1; req_rn = 4'd2;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {31'h0, req_ready}, 32'h0);
    n_reset = 1'b0;
    #1;
    chk("mid_trans", {30'h0, mem_bus.trans}, 32'h0);
    chk("mid_ready", {31'h0, req_ready}, 32'h1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("mid_nowb", {30'h0, wb_valid, wb_base_valid}, 32'h0);
    end
    n_reset = 1'b1;

    issue(1, 0, 0, 1, 0, 32'h104, 32'h4, 32'h0, 4'd1, 4'd2);
    chk("rel_data",  wbv_data, 32'hDEAD_BEEF);
    chk("rel_base",  wbb_data, 32'h108);
    chk("rel_ready", ready_at, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
